sample_rle_stream: RTL and testbench
====================================

Name: sample_rle_stream

Overview:
Parametrised run-length compressor for the sampler pipeline, successor to the current fixed 16-bit compressor. Sits between sample_serializer and the output stream sink.
- Replaces the strobe-gap requirement with a valid/ready input handshake and a small output FIFO with backpressure.
- Adds page restart points, an explicit end-of-capture flush, and a drop counter.

Parameters:
W, 16, data word width (>= 8)
DEPTH, 4, output FIFO depth in words (power of two, >= 2)
PAGE_LOG, 15, log2 of accepted input words per page

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  sync clear: state, FIFO, counters, flags
flush  in  1  pulse: close any open run at end of capture
in_data  in  W  sample word
in_valid  in  1  sample present (source cannot stall)
in_ready  out  1  block can accept in_data this cycle
out_data  out  W  compressed word (FIFO head)
out_first  out  1  head word is first word of a page
out_valid  out  1  FIFO not empty
out_ready  in  1  sink accepts head word
overflow  out  1  sticky: sample offered while in_ready=0
drop_count  out  16  saturating count of dropped samples
state_dbg  out  2+W  {state, cntr} for the debug register

Behaviour:
- Reset (rst_n low, async): state INIT, FIFO empty, out_valid=0, out_first=0, out_data=0, overflow=0, drop_count=0, page counter=0, in_ready=1 (state INIT, FIFO empty). clear has identical effect, synchronously; clear wins over every other input in the same cycle.
- Accept: a sample is accepted when in_valid && in_ready. If in_valid && !in_ready, the sample is dropped, overflow is set, and drop_count increments, saturating at 16'hFFFF.
- in_ready = (state != EMIT_LIT) && (FIFO free slots >= 2). Registered; derived from the current cycle's state and FIFO occupancy.
- Push latency: a pushed word appears on out_data/out_valid one cycle after acceptance when the FIFO is empty. FIFO is first-word fall-through.
- Encoding (unchanged from the previous generation):
  - Literals are emitted as-is.
  - Two equal consecutive literals open a run.
  - Following equal samples are counted in cntr (W bits). When the run ends, cntr (the number of extra repeats) is emitted.
  - When cntr would exceed all-ones minus 1, the block emits all-ones and cntr restarts at 0.
- States:
  - INIT: on accept, push literal -> SINGLE.
  - SINGLE: on accept, push literal. If equal to last, go to RUN with cntr=0; else stay in SINGLE.
  - RUN, accept with equal data: cntr+1. At cntr == all-ones minus 1, push all-ones and set cntr=0.
  - RUN, accept with differing data: push cntr, latch the new literal, go to EMIT_LIT.
  - EMIT_LIT: push the latched literal -> SINGLE. in_ready=0 during this state.
- last_data updates on every accepted sample.
- flush:
  - In RUN: push cntr -> INIT.
  - In EMIT_LIT: complete the literal push, then go to INIT.
  - In INIT or SINGLE: go to INIT, no push.
- Page restart: the page counter counts accepted samples, wrapping at 2^PAGE_LOG. The accepted sample that wraps the counter to 0 acts as an implicit flush after its own processing, so the next sample is encoded from INIT. The first word pushed after clear or after a page wrap carries out_first=1.
- FIFO: a push is never attempted while full; the in_ready margin of 2 guarantees this. A simultaneous pop and push on a full FIFO is legal.
- Stall: out_ready low indefinitely only stalls in_ready. No words are lost inside the block.

Decomposition:
- Shared package sampler_pkg:
  - state enum: INIT=0, SINGLE=1, RUN=2, EMIT_LIT=3.
  - ST_W=2.
  - W-generic all-ones and saturation constants via functions.
- One sub-module: sample_fifo_fwft (W+1 bits wide, DEPTH; data plus first flag). Reusable for the USB path.

Test Plan:
1. W=16. After clear, feed 0x1234, 0x5678, 0x5678, 0x5678, 0x9ABC, each with 1-cycle spacing, out_ready=1 -> out stream 0x1234(first=1), 0x5678, 0x5678, 0x0001, 0x9ABC. in_ready is low for exactly one cycle after 0x9ABC.
2. Feed 0xAAAA for 0x10001 consecutive cycles, then flush -> output 0xAAAA, 0xAAAA, 0xFFFF, then 0x0000 on flush. No drops.
3. Hold out_ready=0 and feed distinct values every cycle -> the first DEPTH-1 words are buffered, then in_ready falls. overflow=1 and drop_count equals the number of cycles offered with in_ready=0. Release out_ready -> buffered words drain in order.
4. PAGE_LOG=3. Feed 8 distinct samples, then 8 more -> out_first=1 on word 0 and word 8 only.
5. PAGE_LOG=3. A constant run spanning a page wrap -> count word is emitted at the wrap, and the new page restarts with two literals.
6. Assert clear mid-run with the FIFO holding 3 words, and separately assert rst_n low mid-run -> out_valid=0 next cycle (async for reset), overflow=0, drop_count=0, next sample is a literal with first=1.

Source files
------------

// File: rtl/sampler_pkg.sv
// Shared types and width-generic constants for the sampler compression path.
package sampler_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_INIT     = 2'd0,
    ST_SINGLE   = 2'd1,
    ST_RUN      = 2'd2,
    ST_EMIT_LIT = 2'd3
  } state_e;

  // Returned 64 bits wide; callers slice down to their own word width.
  function automatic logic [63:0] ones_of(input int unsigned w);
    ones_of = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] run_limit_of(input int unsigned w);
    run_limit_of = ones_of(w) - 64'd1;
  endfunction

endpackage

// File: rtl/sample_fifo_fwft.sv
// First-word-fall-through FIFO; head_data reads as zero while empty.
module sample_fifo_fwft #(
  parameter int DW    = 17,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          head_valid,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // pop is only issued by the owner while head_valid is high
  always_comb begin
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_q] <= push_data;
  end

  assign head_valid = (cnt_q != '0);
  assign head_data  = head_valid ? mem_q[rd_q] : '0;
  assign count      = cnt_q;

endmodule

// File: rtl/sample_rle_stream.sv
// Run-length compressor: literals, run counts, page restart points, flush and
// drop accounting in front of a small FWFT output FIFO.
module sample_rle_stream
  import sampler_pkg::*;
#(
  parameter int W        = 16,
  parameter int DEPTH    = 4,
  parameter int PAGE_LOG = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              flush,
  input  logic [W-1:0]      in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_first,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [15:0]       drop_count,
  output logic [ST_W+W-1:0] state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [63:0]   ONES64    = ones_of(W);
  localparam logic [63:0]   LIMIT64   = run_limit_of(W);
  localparam logic [W-1:0]  ALL_ONES  = ONES64[W-1:0];
  localparam logic [W-1:0]  RUN_LIMIT = LIMIT64[W-1:0];
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  state_e              state_q, state_d;
  logic [W-1:0]        cntr_q, cntr_d, last_q, last_d, lit_q, lit_d;
  logic [PAGE_LOG-1:0] page_q, page_d;
  logic                first_pend_q, first_pend_d;
  logic                pend_init_q, pend_init_d, pend_page_q, pend_page_d;
  logic                overflow_q, overflow_d, in_ready_q, in_ready_d;
  logic [15:0]         drop_q, drop_d;

  logic          accept, drop, wrap, do_flush, push, pop, new_page, fifo_valid;
  logic [W-1:0]  push_data;
  logic [W:0]    fifo_head;
  logic [CW-1:0] fifo_count, count_nxt;

  always_comb begin
    state_d      = state_q;
    cntr_d       = cntr_q;
    last_d       = last_q;
    lit_d        = lit_q;
    page_d       = page_q;
    first_pend_d = first_pend_q;
    pend_init_d  = pend_init_q;
    pend_page_d  = pend_page_q;
    push         = 1'b0;
    push_data    = '0;

    accept   = in_valid && in_ready_q;
    drop     = in_valid && !in_ready_q;
    wrap     = accept && (page_q == '1);
    do_flush = flush || wrap;
    pop      = fifo_valid && out_ready;

    if (accept) begin
      last_d = in_data;
      page_d = page_q + PAGE_LOG'(1);
    end

    unique case (state_q)
      ST_INIT: if (accept) begin
        push      = 1'b1;
        push_data = in_data;
        state_d   = ST_SINGLE;
      end
      ST_SINGLE: if (accept) begin
        push      = 1'b1;
        push_data = in_data;
        if (in_data == last_q) begin
          state_d = ST_RUN;
          cntr_d  = '0;
        end
      end
      ST_RUN: if (accept) begin
        if (in_data != last_q) begin
          push      = 1'b1;
          push_data = cntr_q;
          lit_d     = in_data;
          state_d   = ST_EMIT_LIT;
        end else if (cntr_q == RUN_LIMIT) begin
          push      = 1'b1;
          push_data = ALL_ONES;
          cntr_d    = '0;
        end else begin
          cntr_d = cntr_q + W'(1);
        end
      end
      ST_EMIT_LIT: begin
        push        = 1'b1;
        push_data   = lit_q;
        state_d     = pend_init_q ? ST_INIT : ST_SINGLE;
        pend_init_d = 1'b0;
        pend_page_d = 1'b0;
      end
      default: state_d = ST_INIT;
    endcase

    // A run closed in a cycle that already pushed defers its count word
    // through EMIT_LIT, so at most one word enters the FIFO per cycle.
    if (do_flush) begin
      unique case (state_d)
        ST_RUN: if (!push) begin
          push      = 1'b1;
          push_data = cntr_d;
          state_d   = ST_INIT;
        end else begin
          lit_d       = cntr_d;
          state_d     = ST_EMIT_LIT;
          pend_init_d = 1'b1;
        end
        ST_EMIT_LIT: pend_init_d = 1'b1;
        default:     state_d = ST_INIT;
      endcase
    end

    new_page = (state_q == ST_EMIT_LIT && pend_page_q) ||
               (wrap && state_d != ST_EMIT_LIT);
    if (wrap && state_d == ST_EMIT_LIT) pend_page_d = 1'b1;
    if (push) first_pend_d = 1'b0;
    if (new_page) first_pend_d = 1'b1;

    overflow_d = overflow_q || drop;
    drop_d     = drop_q;
    if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;

    count_nxt  = fifo_count + CW'(push) - CW'(pop);
    in_ready_d = (state_d != ST_EMIT_LIT) && (count_nxt <= READY_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      cntr_q       <= '0;
      last_q       <= '0;
      lit_q        <= '0;
      page_q       <= '0;
      first_pend_q <= 1'b1;
      pend_init_q  <= 1'b0;
      pend_page_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
      in_ready_q   <= 1'b1;
    end else if (clear) begin
      state_q      <= ST_INIT;
      cntr_q       <= '0;
      last_q       <= '0;
      lit_q        <= '0;
      page_q       <= '0;
      first_pend_q <= 1'b1;
      pend_init_q  <= 1'b0;
      pend_page_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cntr_q       <= cntr_d;
      last_q       <= last_d;
      lit_q        <= lit_d;
      page_q       <= page_d;
      first_pend_q <= first_pend_d;
      pend_init_q  <= pend_init_d;
      pend_page_q  <= pend_page_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
      in_ready_q   <= in_ready_d;
    end
  end

  sample_fifo_fwft #(.DW(W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .push       (push),
    .push_data  ({first_pend_q, push_data}),
    .pop        (pop),
    .head_data  (fifo_head),
    .head_valid (fifo_valid),
    .count      (fifo_count)
  );

  assign in_ready   = in_ready_q;
  assign out_data   = fifo_head[W-1:0];
  assign out_first  = fifo_head[W];
  assign out_valid  = fifo_valid;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign state_dbg  = {state_q, cntr_q};

endmodule

// File: tb/tb_sample_rle_stream.sv
// Bench for sample_rle_stream: two instances share stimulus (long pages and
// 8-word pages); sel picks which one is observed.
module tb_sample_rle_stream;

  localparam int W = 16;

  logic         clk, rst_n, clear, flush, in_valid, out_ready, sel;
  logic [W-1:0] in_data;

  logic         a_in_ready, a_out_first, a_out_valid, a_overflow;
  logic [W-1:0] a_out_data;
  logic [15:0]  a_drop_count;
  logic [W+1:0] a_state_dbg;
  logic         b_in_ready, b_out_first, b_out_valid, b_overflow;
  logic [W-1:0] b_out_data;
  logic [15:0]  b_drop_count;
  logic [W+1:0] b_state_dbg;

  logic         s_in_ready, s_out_first, s_out_valid, s_overflow;
  logic [W-1:0] s_out_data;
  logic [15:0]  s_drop_count;

  logic [W:0] exp_q[$];
  logic [W:0] exp_word;
  int total = 0;
  int bad   = 0;

  sample_rle_stream #(.W(W), .DEPTH(4), .PAGE_LOG(17)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_first(a_out_first), .out_valid(a_out_valid),
    .out_ready(out_ready), .overflow(a_overflow), .drop_count(a_drop_count),
    .state_dbg(a_state_dbg)
  );

  sample_rle_stream #(.W(W), .DEPTH(4), .PAGE_LOG(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_first(b_out_first), .out_valid(b_out_valid),
    .out_ready(out_ready), .overflow(b_overflow), .drop_count(b_drop_count),
    .state_dbg(b_state_dbg)
  );

  assign s_in_ready   = sel ? b_in_ready   : a_in_ready;
  assign s_out_first  = sel ? b_out_first  : a_out_first;
  assign s_out_valid  = sel ? b_out_valid  : a_out_valid;
  assign s_out_data   = sel ? b_out_data   : a_out_data;
  assign s_overflow   = sel ? b_overflow   : a_overflow;
  assign s_drop_count = sel ? b_drop_count : a_drop_count;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // scoreboard: every word leaving the selected DUT is matched in order
  always @(negedge clk) begin
    if (rst_n && !clear && s_out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word got first=%0d data=%h expected none",
                 s_out_first, s_out_data);
      end else begin
        exp_word = exp_q.pop_front();
        if ({s_out_first, s_out_data} !== exp_word) begin
          bad++;
          $display("FAIL out_word got first=%0d data=%h expected first=%0d data=%h",
                   s_out_first, s_out_data, exp_word[W], exp_word[W-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic push_exp(input logic first, input logic [W-1:0] d);
    exp_q.push_back({first, d});
  endtask

  task automatic send(input logic [W-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got=%0d words still expected required=0", name, exp_q.size());
    end
    total++;
    if (s_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_extra out_valid got=%0d required=0", name, s_out_valid);
    end
  endtask

  // tests
  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({s_out_valid, s_out_first, s_out_data} !== {2'b00, 16'h0000}) begin
      bad++;
      $display("FAIL reset_out got valid=%0d first=%0d data=%h required 0/0/0000",
               s_out_valid, s_out_first, s_out_data);
    end
    total++;
    if (s_overflow !== 1'b0 || s_drop_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_flags got ovf=%0d drops=%0d required 0/0", s_overflow, s_drop_count);
    end
    total++;
    if (s_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%0d required=1", s_in_ready);
    end
  endtask

  task automatic test_basic();
    sel = 1'b0;
    do_clear();
    push_exp(1'b1, 16'h1234);
    push_exp(1'b0, 16'h5678);
    push_exp(1'b0, 16'h5678);
    push_exp(1'b0, 16'h0001);
    push_exp(1'b0, 16'h9ABC);
    send(16'h1234); idle(1);
    send(16'h5678); idle(1);
    send(16'h5678); idle(1);
    send(16'h5678); idle(1);
    send(16'h9ABC);
    @(negedge clk);
    total++;
    if (s_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_emit_stall in_ready got=%0d required=0", s_in_ready);
    end
    @(negedge clk);
    total++;
    if (s_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_emit_recover in_ready got=%0d required=1", s_in_ready);
    end
    @(posedge clk); #1;
    do_flush();
    drain("basic", 20);
  endtask

  task automatic test_long_run();
    sel = 1'b0;
    do_clear();
    push_exp(1'b1, 16'hAAAA);
    push_exp(1'b0, 16'hAAAA);
    push_exp(1'b0, 16'hFFFF);
    push_exp(1'b0, 16'h0000);
    in_data  = 16'hAAAA;
    in_valid = 1'b1;
    repeat (32'h10001) @(posedge clk);
    #1;
    in_valid = 1'b0;
    do_flush();
    drain("long_run", 20);
    total++;
    if (s_drop_count !== 16'd0 || s_overflow !== 1'b0) begin
      bad++;
      $display("FAIL long_run_drops got ovf=%0d drops=%0d required 0/0", s_overflow, s_drop_count);
    end
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data  = 16'h1000 + 16'(i);
      in_valid = 1'b1;
      if (i < 3) push_exp(i == 0, in_data);
      @(negedge clk);
      total++;
      if (s_in_ready !== 1'(i < 3)) begin
        bad++;
        $display("FAIL bp_in_ready[%0d] got=%0d required=%0d", i, s_in_ready, (i < 3));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    idle(4);
    @(negedge clk);
    total++;
    if (s_overflow !== 1'b1 || s_drop_count !== 16'd5) begin
      bad++;
      $display("FAIL bp_drops got ovf=%0d drops=%0d required 1/5", s_overflow, s_drop_count);
    end
    total++;
    if (s_out_valid !== 1'b1 || s_out_data !== 16'h1000) begin
      bad++;
      $display("FAIL bp_held_head got valid=%0d data=%h required 1/1000", s_out_valid, s_out_data);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("backpressure", 20);
  endtask

  task automatic test_page_distinct();
    sel = 1'b1;
    do_clear();
    for (int i = 0; i < 16; i++) begin
      in_data  = 16'h2000 + 16'(i);
      in_valid = 1'b1;
      push_exp((i == 0) || (i == 8), in_data);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("page_distinct", 20);
  endtask

  task automatic test_page_run();
    sel = 1'b1;
    do_clear();
    push_exp(1'b1, 16'h0C0C);
    push_exp(1'b0, 16'h0C0C);
    push_exp(1'b0, 16'h0006);
    push_exp(1'b1, 16'h0C0C);
    push_exp(1'b0, 16'h0C0C);
    push_exp(1'b0, 16'h0002);
    in_data  = 16'h0C0C;
    in_valid = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    in_valid = 1'b0;
    do_flush();
    drain("page_run", 20);
  endtask

  task automatic test_flush_emit_lit();
    sel = 1'b0;
    do_clear();
    push_exp(1'b1, 16'h00A1);
    push_exp(1'b0, 16'h00A1);
    push_exp(1'b0, 16'h0000);
    push_exp(1'b0, 16'h00B2);
    push_exp(1'b0, 16'h00B2);
    send(16'h00A1);
    send(16'h00A1);
    send(16'h00B2);
    do_flush();
    send(16'h00B2);
    do_flush();
    drain("flush_emit", 20);
  endtask

  task automatic test_clear_mid_run();
    sel = 1'b0;
    do_clear();
    out_ready = 1'b0;
    send(16'h3000);
    send(16'h3111);
    send(16'h3111);
    send(16'h3111);
    @(negedge clk);
    total++;
    if (s_overflow !== 1'b1 || s_drop_count !== 16'd1) begin
      bad++;
      $display("FAIL clr_pre_drops got ovf=%0d drops=%0d required 1/1", s_overflow, s_drop_count);
    end
    do_clear();
    @(negedge clk);
    total++;
    if (s_out_valid !== 1'b0 || s_overflow !== 1'b0 || s_drop_count !== 16'd0) begin
      bad++;
      $display("FAIL clr_state got valid=%0d ovf=%0d drops=%0d required 0/0/0",
               s_out_valid, s_overflow, s_drop_count);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_exp(1'b1, 16'h3111);
    send(16'h3111);
    drain("clear_mid_run", 20);
  endtask

  task automatic test_reset_mid_run();
    sel = 1'b0;
    do_clear();
    out_ready = 1'b0;
    send(16'h4000);
    send(16'h4222);
    send(16'h4222);
    send(16'h4222);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (s_out_valid !== 1'b0 || s_overflow !== 1'b0 || s_drop_count !== 16'd0) begin
      bad++;
      $display("FAIL async_reset got valid=%0d ovf=%0d drops=%0d required 0/0/0",
               s_out_valid, s_overflow, s_drop_count);
    end
    #3;
    rst_n = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    push_exp(1'b1, 16'h4222);
    send(16'h4222);
    drain("reset_mid_run", 20);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    sel       = 1'b0;
    #12;
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_long_run();
    test_backpressure();
    test_page_distinct();
    test_page_run();
    test_flush_emit_lit();
    test_clear_mid_run();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
